// File: rtl/req_queue.sv
// req_queue: per-requester valid/ready FIFO placed upstream of an arbiter input.
// First-word-fall-through. Every output decodes from registered state only, so
// the producer and the arbiter grant logic have no combinational path between them.
module req_queue #(
  parameter int DWIDTH   = 20,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DWIDTH-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  // Output decodes: registers only. in_ready stays low when full even if a pop
  // happens this cycle, so in_ready never depends on out_ready.
  always_comb begin
    in_ready    = (count_q != FULL_CNT);
    out_valid   = (count_q != '0);
    out_data    = mem_q[rp_q];
    count       = count_q;
    almost_full = (count_q >= AFULL_CNT);
  end

  // Next-state for pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage array; written at the write pointer on each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset so out_data reads 0 after reset instead of stale words.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_req_queue.sv
// Self-checking bench for req_queue. A queue-based reference model tracks the
// expected contents; outputs are compared #1 after each rising edge.
module tb_req_queue;

  localparam int DWIDTH   = 20;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic [2:0]        count;
  logic              almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DWIDTH-1:0] model[$];

  req_queue #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_outputs(input string tag);
    int sz;
    sz = model.size();
    check({tag, ".count"},       32'(count),       32'(sz));
    check({tag, ".out_valid"},   32'(out_valid),   32'(sz != 0));
    check({tag, ".in_ready"},    32'(in_ready),    32'(sz != DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AFULL_TH));
    if (sz != 0) check({tag, ".out_data"}, 32'(out_data), 32'(model[0]));
  endtask

  // One clock: drive inputs, predict handshakes from the model, step, compare.
  task automatic cycle(input string tag, input logic v, input logic [DWIDTH-1:0] d,
                       input logic r);
    bit do_push, do_pop;
    logic [DWIDTH-1:0] tmp;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push   = v && (model.size() < DEPTH);
    do_pop    = r && (model.size() > 0);
    @(posedge clk);
    if (do_pop) tmp = model.pop_front();
    if (do_push) model.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count"},       32'(count),       32'd0);
    check({tag, ".out_valid"},   32'(out_valid),   32'd0);
    check({tag, ".in_ready"},    32'(in_ready),    32'd1);
    check({tag, ".out_data"},    32'(out_data),    32'd0);
    check({tag, ".almost_full"}, 32'(almost_full), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;

    // Two words queued, then asynchronous reset mid-cycle.
    cycle("pre_rst_push0", 1'b1, 20'h000A1, 1'b0);
    cycle("pre_rst_push1", 1'b1, 20'h000A2, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model.delete();
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("idle_pop", 1'b0, '0, 1'b1);
    check("idle_pop_count", 32'(count), 32'd0);

    // Fill to full with out_ready low.
    for (int i = 1; i <= 4; i++) begin
      cycle("fill", 1'b1, DWIDTH'(i), 1'b0);
      check("fill_count_step", 32'(count), 32'(i));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    // Fifth word offered while full is held, not accepted.
    cycle("hold5", 1'b1, 20'h00005, 1'b0);
    check("hold5_head", 32'(out_data), 32'h00001);

    // Pop from full while 0x5 still offered: no push this cycle.
    cycle("full_pop", 1'b1, 20'h00005, 1'b1);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_head", 32'(out_data), 32'h00002);
    cycle("accept5", 1'b1, 20'h00005, 1'b0);
    check("accept5_count", 32'(count), 32'd4);

    // Drain across the pointer wrap.
    for (int i = 2; i <= 5; i++) begin
      check("drain_head", 32'(out_data), 32'(i));
      cycle("drain", 1'b0, '0, 1'b1);
    end
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_count", 32'(count), 32'd0);

    // Streaming: push and pop every cycle, occupancy settles at 1.
    for (int i = 0; i < 100; i++) begin
      cycle("stream", 1'b1, DWIDTH'(20'h10000 + i), 1'b1);
      check("stream_count", 32'(count), 32'd1);
      check("stream_data", 32'(out_data), 32'(20'h10000 + i));
    end
    cycle("stream_tail", 1'b0, '0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), DWIDTH'($urandom),
            1'($urandom_range(0, 1)));
    end

    // Random fill, then reset clears everything.
    for (int i = 0; i < 3; i++) cycle("prefill", 1'b1, DWIDTH'($urandom), 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    model.delete();
    check_reset_values("async_rst2");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst2", 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
